fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit_pkg.sv | 42 ++++
 rtl/fwd_hazard_unit_tag_cmp.sv | 25 ++
 rtl/fwd_hazard_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// ============================================================================
// Module  : fwd_hazard_unit_pkg
// Brief   : Shared tag type, width constants and operand-select encodings
//           for the forwarding / hazard unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_hazard_unit_pkg;

    localparam int REG_W = 5;
    localparam int FWD_W = 2;
    localparam int CNT_W = 16;

    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwr;
        logic             memrd;
    } tag_t;

    localparam tag_t TAG_NONE = '0;

    // The youngest producer (EX) wins over the older one (MEM).
    function automatic logic [FWD_W-1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EXMEM;
        else if (mem_hit)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_tag_cmp.sv
// ============================================================================
// Module  : fwd_tag_cmp
// Brief   : Combinational match of one pipeline tag against one source index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_tag_cmp
    import fwd_hazard_unit_pkg::*;
(
    input  tag_t             tag,
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    output logic             match
);

    // $0 is hard-wired, so a write to it never produces a dependency.
    assign match = tag.valid & tag.regwr & uses & (tag.rd == src) & (src != '0);

    logic unused_memrd;
    assign unused_memrd = tag.memrd;

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module  : fwd_hazard_unit
// Brief   : Tracks EX/MEM/WB destination tags, produces operand forwarding
//           selects and load-use stall/bubble control.  Forwarding is
//           enabled by the FWD_HAZARD_FWD_EN macro; without it every EX/MEM
//           dependency stalls and the selects are tied to the register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_ID_Valid,
    input  logic [REG_W-1:0] i_ID_Rs,
    input  logic [REG_W-1:0] i_ID_Rt,
    input  logic             i_ID_UsesRs,
    input  logic             i_ID_UsesRt,
    input  logic [REG_W-1:0] i_ID_Rd,
    input  logic             i_ID_RegWr,
    input  logic             i_ID_MemRd,
    input  logic             i_Flush,
    output logic             o_StallPC,
    output logic             o_StallIFID,
    output logic             o_BubbleIDEX,
    output logic [FWD_W-1:0] o_FwdA,
    output logic [FWD_W-1:0] o_FwdB,
    output logic [CNT_W-1:0] o_StallCnt
);

    tag_t             r_ex;
    tag_t             r_mem;
    tag_t             r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    tag_t w_id_tag;
    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
    logic w_hazard, w_stall, w_bubble;

    assign w_id_tag = '{valid: i_ID_Valid, rd: i_ID_Rd, regwr: i_ID_RegWr, memrd: i_ID_MemRd};

    fwd_tag_cmp u_cmp_ex_rs  (.tag(r_ex),  .src(i_ID_Rs), .uses(i_ID_UsesRs), .match(w_ex_rs));
    fwd_tag_cmp u_cmp_ex_rt  (.tag(r_ex),  .src(i_ID_Rt), .uses(i_ID_UsesRt), .match(w_ex_rt));
    fwd_tag_cmp u_cmp_mem_rs (.tag(r_mem), .src(i_ID_Rs), .uses(i_ID_UsesRs), .match(w_mem_rs));
    fwd_tag_cmp u_cmp_mem_rt (.tag(r_mem), .src(i_ID_Rt), .uses(i_ID_UsesRt), .match(w_mem_rt));

`ifdef FWD_HAZARD_FWD_EN
    logic [FWD_W-1:0] r_fwd_a;
    logic [FWD_W-1:0] r_fwd_b;

    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    assign w_hazard = i_ID_Valid & r_ex.memrd & (w_ex_rs | w_ex_rt);

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_bubble) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= fwd_sel(w_ex_rs, w_mem_rs);
            r_fwd_b <= fwd_sel(w_ex_rt, w_mem_rt);
        end
    end

    assign o_FwdA = r_fwd_a;
    assign o_FwdB = r_fwd_b;
`else
    assign w_hazard = i_ID_Valid & (w_ex_rs | w_ex_rt | w_mem_rs | w_mem_rt);
    assign o_FwdA   = FWD_RF;
    assign o_FwdB   = FWD_RF;
`endif

    // Flush overrides the stall; reset drops any stall in progress.
    assign w_stall  = w_hazard & ~i_Flush & i_RST;
    assign w_bubble = w_hazard | i_Flush | ~i_ID_Valid;

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            r_ex        <= TAG_NONE;
            r_mem       <= TAG_NONE;
            r_wb        <= TAG_NONE;
            r_stall_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_bubble ? TAG_NONE : w_id_tag;
            if (w_stall && (r_stall_cnt != C_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // WB is tracked for completeness but the write-before-read regfile covers it.
    logic unused_wb;
    assign unused_wb = ^r_wb;

    assign o_StallPC    = w_stall;
    assign o_StallIFID  = w_stall;
    assign o_BubbleIDEX = w_bubble;
    assign o_StallCnt   = r_stall_cnt;

endmodule

`default_nettype wire
